spi_flash_reader: RTL and testbench



---
 rtl/spi_flash_reader_pkg.sv | 24 ++
 rtl/spi_flash_sck_gen.sv | 38 +++
 rtl/spi_flash_reader.sv | 151 +++++++++++++++
 tb/tb_spi_flash_reader.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_reader_pkg.sv
// SPI flash reader shared definitions:
// read opcode, frame bit counts and FSM encoding.
package spi_flash_reader_pkg;

    localparam logic [7:0] READ      = 8'h03;
    localparam int         CMD_BITS  = 8;
    localparam int         ADDR_BITS = 24;
    localparam int         WORD_BITS = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_DESEL
    } state_t;

    // Bytes arrive first-byte-in-MSB; the word is little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_sck_gen.sv
// SPI mode-0 clock generator with one-cycle
// rise/fall strobes; clock parks low when disabled.
module spi_flash_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;
    logic       tick;

    assign tick = en && (cnt == LAST);
    assign rise = tick && !sck;
    assign fall = tick && sck;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash READ (0x03) engine: streams len
// 32-bit little-endian words through a valid/ready register.
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CSB_HIGH = 4
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        rready,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    state_t      state;
    state_t      state_d;
    logic [31:0] shreg;
    logic [31:0] rx_sh;
    logic [4:0]  bit_cnt;
    logic [15:0] words_left;
    logic [7:0]  desel_cnt;
    logic        sck_en;
    logic        rise;
    logic        fall;
    logic        load;
    logic        accept;
    logic        out_free;
    logic        last_word;
    logic        sel_d;

    assign sck_en    = (state == S_CMD) || (state == S_ADDR)
                    || (state == S_DATA);
    assign accept    = (state == S_IDLE) && start;
    assign out_free  = !rvalid || rready;
    assign last_word = (words_left == 16'd1);
    assign sel_d     = (state_d == S_CMD) || (state_d == S_ADDR)
                    || (state_d == S_DATA) || (state_d == S_HOLD);
    assign flash_io0 = shreg[31];

    spi_flash_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck (
        .clock (clock),
        .resetb(resetb),
        .en    (sck_en),
        .sck   (flash_clk),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        state_d = state;
        load    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start)
                    state_d = (len == 16'd0) ? S_DESEL : S_CMD;
            end
            S_CMD: begin
                if (fall && bit_cnt == 5'(CMD_BITS - 1))
                    state_d = S_ADDR;
            end
            S_ADDR: begin
                if (fall && bit_cnt == 5'(ADDR_BITS - 1))
                    state_d = S_DATA;
            end
            S_DATA: begin
                if (fall && bit_cnt == 5'(WORD_BITS - 1)) begin
                    if (out_free) begin
                        load = 1'b1;
                        if (last_word)
                            state_d = S_DESEL;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_free) begin
                    load    = 1'b1;
                    state_d = last_word ? S_DESEL : S_DATA;
                end
            end
            S_DESEL: begin
                if (desel_cnt == 8'd0)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state      <= S_IDLE;
            flash_csb  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            shreg      <= '0;
            rx_sh      <= '0;
            bit_cnt    <= '0;
            words_left <= '0;
            desel_cnt  <= '0;
            rdata      <= '0;
            rvalid     <= 1'b0;
        end else begin
            state     <= state_d;
            flash_csb <= !sel_d;
            busy      <= (state_d != S_IDLE);
            done      <= (state == S_DESEL) && (state_d == S_IDLE);

            if (accept) begin
                shreg      <= (len == 16'd0) ? '0 : {READ, addr};
                words_left <= len;
                bit_cnt    <= '0;
            end else if (fall) begin
                shreg   <= {shreg[30:0], 1'b0};
                bit_cnt <= (state_d != state) ? '0 : bit_cnt + 5'd1;
            end

            if (rise && state == S_DATA)
                rx_sh <= {rx_sh[30:0], flash_io1};

            // An empty transfer never selected the flash, so no deselect wait.
            if (accept)
                desel_cnt <= '0;
            else if (state_d == S_DESEL && state != S_DESEL)
                desel_cnt <= 8'(CSB_HIGH - 1);
            else if (state == S_DESEL && desel_cnt != 8'd0)
                desel_cnt <= desel_cnt - 8'd1;

            if (load) begin
                rdata      <= bswap32(rx_sh);
                rvalid     <= 1'b1;
                words_left <= words_left - 16'd1;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench: three readers (CLK_DIV 2,1,4) against a
// behavioural SPI flash holding a 256-byte image.
module tb_spi_flash_reader;

    logic        clock    = 1'b0;
    logic        resetb   = 1'b0;
    logic        start    = 1'b0;
    logic [23:0] addr_i   = '0;
    logic [15:0] len_i    = '0;
    logic        rr_fixed = 1'b1;
    logic        rr_rand  = 1'b1;
    logic        rnd_mode = 1'b0;
    logic        clr      = 1'b0;
    logic        rready;

    logic [2:0]  busy_v, done_v, rvalid_v;
    logic [2:0]  csb_v, sck_v, io0_v, io1_v;
    logic [31:0] rdata_v [3];

    logic [7:0]  img [256];
    int          checks = 0;
    int          errors = 0;

    int          cyc = 0;
    logic [31:0] got [3][8];
    int          ngot [3];
    int          ndone [3];
    int          done_cyc [3];
    int          busy_cyc [3];
    int          desel_run [3];
    int          hi_run [3];
    int          last_rise [3];
    int          min_per [3];
    int          io0_bad [3];
    bit   [2:0]  low_seen;
    logic [2:0]  busy_p, sck_p, io0_p;

    typedef struct packed {
        logic [23:0]      a;
        logic [15:0]      n;
        logic             rnd;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t tbl [6];

    assign rready = rnd_mode ? rr_rand : rr_fixed;

    always #5 clock = ~clock;

    always @(posedge clock) rr_rand <= (($urandom & 3) != 0);

    function automatic logic fbit(input logic [23:0] a, input int k);
        logic [7:0] b;
        b = img[(int'(a) + k / 8) & 255];
        return b[7 - (k % 8)];
    endfunction

    function automatic logic [31:0] ref_word(input logic [23:0] a,
                                             input int k);
        logic [31:0] w;
        for (int b = 0; b < 4; b++)
            w[8*b +: 8] = img[(int'(a) + 4 * k + b) & 255];
        return w;
    endfunction

    function automatic logic [3:0][31:0] exp_of(input logic [23:0] a,
                                                input int n);
        logic [3:0][31:0] e;
        e = '0;
        for (int k = 0; k < 4; k++)
            if (k < n) e[k] = ref_word(a, k);
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int DIV = (g == 1) ? 1 : ((g == 2) ? 4 : 2);
        int          nbits = 0;
        logic [31:0] hdr   = '0;
        logic        miso  = 1'b0;

        assign io1_v[g] = miso;

        spi_flash_reader #(
            .CLK_DIV (DIV),
            .CSB_HIGH(4)
        ) u_dut (
            .clock    (clock),
            .resetb   (resetb),
            .start    (start),
            .addr     (addr_i),
            .len      (len_i),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .rdata    (rdata_v[g]),
            .rvalid   (rvalid_v[g]),
            .rready   (rready),
            .flash_csb(csb_v[g]),
            .flash_clk(sck_v[g]),
            .flash_io0(io0_v[g]),
            .flash_io1(io1_v[g])
        );

        always @(posedge sck_v[g] or posedge csb_v[g]) begin
            if (csb_v[g]) begin
                nbits <= 0;
            end else begin
                if (nbits < 32) hdr <= {hdr[30:0], io0_v[g]};
                nbits <= nbits + 1;
            end
        end

        always @(negedge sck_v[g]) begin
            if (!csb_v[g] && nbits >= 32)
                miso <= fbit(hdr[23:0], nbits - 32);
        end
    end

    always @(negedge clock) begin
        cyc    <= cyc + 1;
        busy_p <= busy_v;
        sck_p  <= sck_v;
        io0_p  <= io0_v;
        for (int i = 0; i < 3; i++) begin
            hi_run[i] <= csb_v[i] ? hi_run[i] + 1 : 0;
            if (clr) begin
                ngot[i]      <= 0;
                ndone[i]     <= 0;
                done_cyc[i]  <= 0;
                busy_cyc[i]  <= 0;
                desel_run[i] <= 0;
                last_rise[i] <= -1;
                min_per[i]   <= 1000;
                io0_bad[i]   <= 0;
                low_seen[i]  <= 1'b0;
            end else begin
                if (rvalid_v[i] && rready) begin
                    if (ngot[i] < 8) got[i][ngot[i]] <= rdata_v[i];
                    ngot[i] <= ngot[i] + 1;
                end
                if (done_v[i]) begin
                    ndone[i]     <= ndone[i] + 1;
                    done_cyc[i]  <= cyc;
                    desel_run[i] <= hi_run[i];
                end
                if (!csb_v[i]) low_seen[i] <= 1'b1;
                if (busy_v[i] && !busy_p[i]) busy_cyc[i] <= cyc;
                if (sck_v[i] && !sck_p[i]) begin
                    if (last_rise[i] >= 0 && cyc - last_rise[i] < min_per[i])
                        min_per[i] <= cyc - last_rise[i];
                    last_rise[i] <= cyc;
                end
                if (sck_v[i] && sck_p[i] && io0_v[i] != io0_p[i])
                    io0_bad[i] <= io0_bad[i] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic begin_xfer(input logic [23:0] a, input logic [15:0] n);
        clr = 1'b1;
        tick();
        clr    = 1'b0;
        addr_i = a;
        len_i  = n;
        start  = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while ((busy_v != 3'b000 || rvalid_v != 3'b000) && c < 30000) begin
            tick();
            c++;
        end
        chk(name, 32'(c < 30000), 32'd1);
        repeat (3) tick();
    endtask

    task automatic check_words(input string name, input logic [15:0] n,
                               input logic [3:0][31:0] e);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_cnt%0d", name, i), ngot[i], 32'(n));
            for (int k = 0; k < 4; k++)
                if (k < int'(n))
                    chk($sformatf("%s_w%0d_%0d", name, i, k), got[i][k], e[k]);
        end
    endtask

    initial begin
        int          c;
        int          bad;
        logic [31:0] held;

        for (int i = 0; i < 256; i++)
            img[i] = 8'((i * 73 + 29) ^ (i >> 3));

        tbl[0] = '{a: 24'h000000, n: 16'd1, rnd: 1'b0, exp: '0};
        tbl[1] = '{a: 24'h000007, n: 16'd2, rnd: 1'b1, exp: '0};
        tbl[2] = '{a: 24'hFFFFFE, n: 16'd2, rnd: 1'b0, exp: '0};
        tbl[3] = '{a: 24'h0000A0, n: 16'd4, rnd: 1'b1, exp: '0};
        for (int t = 4; t < 6; t++) begin
            tbl[t].a   = 24'($urandom);
            tbl[t].n   = 16'($urandom_range(1, 4));
            tbl[t].rnd = 1'b1;
        end
        for (int t = 0; t < 6; t++)
            tbl[t].exp = exp_of(tbl[t].a, int'(tbl[t].n));

        clr    = 1'b1;
        resetb = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ctl%0d", i),
                {csb_v[i], sck_v[i], io0_v[i], busy_v[i], done_v[i], rvalid_v[i]},
                32'b100000);
            chk($sformatf("rst_rdata%0d", i), rdata_v[i], 32'h0);
        end
        resetb = 1'b1;
        tick();
        clr = 1'b0;
        tick();

        // basic two-word read from address 0
        begin_xfer(24'h000000, 16'd2);
        wait_idle("t21_timeout");
        check_words("t21", 16'd2, exp_of(24'h0, 2));
        chk("t21_hdr0", gi[0].hdr, 32'h03000000);
        chk("t21_hdr2", gi[2].hdr, 32'h03000000);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t21_done%0d", i), ndone[i], 32'd1);
            chk($sformatf("t21_desel%0d", i), 32'(desel_run[i] >= 4), 32'd1);
            chk($sformatf("t21_period%0d", i), min_per[i],
                (i == 1) ? 32'd2 : ((i == 2) ? 32'd8 : 32'd4));
            chk($sformatf("t21_io0_hi%0d", i), io0_bad[i], 32'd0);
        end

        for (int t = 0; t < 6; t++) begin
            rnd_mode = tbl[t].rnd;
            begin_xfer(tbl[t].a, tbl[t].n);
            wait_idle($sformatf("tbl%0d_timeout", t));
            rnd_mode = 1'b0;
            check_words($sformatf("tbl%0d", t), tbl[t].n, tbl[t].exp);
            chk($sformatf("tbl%0d_hdr", t), gi[0].hdr, {8'h03, tbl[t].a});
            chk($sformatf("tbl%0d_io0", t), io0_bad[0] + io0_bad[1] + io0_bad[2], 32'd0);
        end

        begin_xfer(24'h000055, 16'd0);
        wait_idle("len0_timeout");
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("len0_lat%0d", i), done_cyc[i] - busy_cyc[i], 32'd1);
            chk($sformatf("len0_csb%0d", i), 32'(low_seen[i]), 32'd0);
            chk($sformatf("len0_done%0d", i), ndone[i], 32'd1);
        end

        // consumer stall: flash clock must park low with CS held
        rr_fixed = 1'b0;
        begin_xfer(24'h000030, 16'd3);
        c = 0;
        while (!rvalid_v[0] && c < 5000) begin
            tick();
            c++;
        end
        chk("stall_wait", 32'(c < 5000), 32'd1);
        held = rdata_v[0];
        bad  = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (k >= 200) begin
                if (sck_v[0] || csb_v[0] || !rvalid_v[0] || rdata_v[0] !== held)
                    bad++;
                if (sck_v[1] || csb_v[1])
                    bad++;
            end
        end
        chk("stall_static", bad, 32'd0);
        rr_fixed = 1'b1;
        wait_idle("stall_timeout");
        check_words("stall", 16'd3, exp_of(24'h30, 3));

        // word left pending after done
        rr_fixed = 1'b0;
        begin_xfer(24'h000044, 16'd1);
        c = 0;
        while (busy_v != 3'b000 && c < 10000) begin
            tick();
            c++;
        end
        chk("pend_timeout", 32'(c < 10000), 32'd1);
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pend_valid%0d", i), 32'(rvalid_v[i]), 32'd1);
            chk($sformatf("pend_done%0d", i), ndone[i], 32'd1);
            chk($sformatf("pend_ngot%0d", i), ngot[i], 32'd0);
        end
        rr_fixed = 1'b1;
        wait_idle("pend_drain");
        check_words("pend", 16'd1, exp_of(24'h44, 1));

        // start while busy is ignored
        begin_xfer(24'h000020, 16'd2);
        repeat (20) tick();
        addr_i = 24'h000080;
        len_i  = 16'd1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("rebusy_timeout");
        check_words("rebusy", 16'd2, exp_of(24'h20, 2));
        chk("rebusy_hdr", gi[0].hdr, 32'h03000020);
        chk("rebusy_done", ndone[0], 32'd1);

        // reset in the middle of the data phase
        begin_xfer(24'h000000, 16'd4);
        repeat (200) tick();
        resetb = 1'b0;
        #2;
        for (int i = 0; i < 3; i++)
            chk($sformatf("arst%0d", i),
                {csb_v[i], sck_v[i], busy_v[i], rvalid_v[i]}, 32'b1000);
        repeat (3) tick();
        resetb = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++)
            chk($sformatf("arst_nodone%0d", i), ndone[i], 32'd0);
        begin_xfer(24'h000010, 16'd1);
        wait_idle("post_rst_timeout");
        check_words("post_rst", 16'd1, exp_of(24'h10, 1));
        chk("post_rst_w4", got[0][0], {img[19], img[18], img[17], img[16]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
